alu_16bit: RTL and testbench
============================

Name: alu_16bit

Overview:
- 16-bit registered ALU for the Rechenwerk datapath.
- Performs one logic or arithmetic operation per clock, selected by a 3-bit opcode (MIPS-style encoding).
- Registers the 16-bit result and a 4-bit status register (C, Z, N, V) for the control unit and branch logic.
- Arithmetic runs through a single 16-bit adder sub-module; subtraction is done as a + ~b + 1.

Parameters:
- WIDTH, 16, operand/result width. Flag rules below are written for 16 bits; the MSB is bit WIDTH-1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  capture enable; when low, outputs hold their values
- a  input  16  operand A
- b  input  16  operand B
- ALUOp  input  3  operation select
- result  output  16  registered result
- sreg  output  4  registered status: [0]=C, [1]=Z, [2]=N, [3]=V

Behaviour:
- Reset: while rst_n=0, result=0 and sreg=0000, asynchronously and regardless of clk or en.
- Latency: a, b and ALUOp are sampled on the rising clk edge when en=1. result and sreg update on that same edge (1-cycle latency). No other handshake.
- When en=0: result and sreg hold.
- Reset asserted mid-operation: outputs clear immediately, and any pending operation is discarded.
- Opcodes:
  - 000 AND: a & b
  - 001 OR: a | b
  - 010 ADD: a + b, modulo 2^16
  - 011 XOR: a ^ b
  - 100 NOR: ~(a | b)
  - 101 MOV: b
  - 110 SUB: a - b, modulo 2^16
  - 111 SLT: 0x0001 if signed a < signed b, else 0x0000
- Z flag, all ops: set when the new result == 0.
- N flag, all ops: set to result[15].
- C and V for logic and MOV ops: both cleared to 0.
- C and V for ADD:
  - C = carry out of bit 15.
  - V = signed overflow (a[15]==b[15] and result[15]!=a[15]).
- C and V for SUB:
  - C = borrow, set when unsigned a < unsigned b. Equivalently C = NOT adder carry-out.
  - V = signed overflow (a[15]!=b[15] and result[15]!=a[15]).
- SLT:
  - Internally computes a - b.
  - Signed less-than = diff[15] XOR V_sub.
  - C and V are taken from that subtraction; Z and N come from the 0/1 result.
- Boundary wrap-around:
  - 65535+1 gives 0 with C=1, Z=1.
  - 15-16 gives 65535 with C=1, N=1.

Decomposition:
- Shared package alu_pkg holds:
  - ALUOp localparams: ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_NOR, ALU_MOV, ALU_SUB, ALU_SLT
  - SREG bit-index constants: SREG_C=0, SREG_Z=1, SREG_N=2, SREG_V=3
- One sub-module, adder_16bit: combinational a + b + cin, producing sum[15:0] and cout.
- The ALU instantiates adder_16bit once. For SUB and SLT it feeds ~b with cin=1.
- The opcode mux and flag logic are combinational; a single output register stage follows them.

Test Plan:
- Reset with rst_n=0 mid-run -> result=0, sreg=0000 immediately. Release, then AND a=7, b=1 -> next edge result=1, sreg=0000.
- OR a=5, b=2 -> result=7, sreg=0000. With en=0 and new inputs applied, outputs stay 7/0000.
- ADD cases:
  - a=16, b=1 -> result=17, sreg=0000
  - a=65535, b=0 -> result=65535, N=1 (sreg=0100)
  - a=65535, b=1 -> result=0, C=1, Z=1 (sreg=0011)
  - a=65535, b=2 -> result=1, C=1 (sreg=0001)
- SUB cases:
  - a=15, b=8 -> result=7, sreg=0000
  - a=15, b=15 -> result=0, Z=1 (sreg=0010)
  - a=15, b=16 -> result=65535, C=1, N=1 (sreg=0101)
- Signed overflow cases:
  - ADD a=0x7FFF, b=1 -> result=0x8000, N=1, V=1 (sreg=1100)
  - SUB a=0x8000, b=1 -> result=0x7FFF, V=1 (sreg=1000)
- SLT a=0xFFFF (-1), b=1 -> result=1. SLT a=1, b=0xFFFF -> result=0, Z=1.
- XOR, NOR and MOV with a=0x00FF, b=0x0F0F:
  - XOR -> result=0x0FF0
  - NOR -> result=0xF000, N=1
  - MOV -> result=0x0F0F
  - All three have C=V=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings and status-register bit positions for the Rechenwerk ALU.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam int unsigned SREG_C = 0;
    localparam int unsigned SREG_Z = 1;
    localparam int unsigned SREG_N = 2;
    localparam int unsigned SREG_V = 3;

endpackage

// File: rtl/adder_16bit.sv
// Combinational ripple-free adder: sum = a + b + cin with carry out.
module adder_16bit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] total;

    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sum   = total[WIDTH-1:0];
        cout  = total[WIDTH];
    end

endmodule

// File: rtl/alu_16bit.sv
// Registered ALU: one logic/arithmetic op per enabled clock, with C/Z/N/V status.
module alu_16bit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ALUOp,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       sreg
);

    localparam int unsigned Msb = WIDTH - 1;

    logic             do_sub;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf_add;
    logic             ovf_sub;

    logic [WIDTH-1:0] op_result;
    logic             op_c;
    logic             op_v;

    logic [WIDTH-1:0] result_d, result_q;
    logic [3:0]       sreg_d, sreg_q;

    // SUB and SLT share the adder as a + ~b + 1
    assign do_sub = (ALUOp == ALU_SUB) || (ALUOp == ALU_SLT);
    assign add_b  = do_sub ? ~b : b;

    adder_16bit #(
        .WIDTH(WIDTH)
    ) u_adder (
        .a   (a),
        .b   (add_b),
        .cin (do_sub),
        .sum (sum),
        .cout(cout)
    );

    assign ovf_add = (a[Msb] == b[Msb]) && (sum[Msb] != a[Msb]);
    assign ovf_sub = (a[Msb] != b[Msb]) && (sum[Msb] != a[Msb]);

    always_comb begin
        op_result = '0;
        op_c      = 1'b0;
        op_v      = 1'b0;
        case (ALUOp)
            ALU_AND: op_result = a & b;
            ALU_OR:  op_result = a | b;
            ALU_XOR: op_result = a ^ b;
            ALU_NOR: op_result = ~(a | b);
            ALU_MOV: op_result = b;
            ALU_ADD: begin
                op_result = sum;
                op_c      = cout;
                op_v      = ovf_add;
            end
            ALU_SUB: begin
                op_result = sum;
                op_c      = ~cout;
                op_v      = ovf_sub;
            end
            ALU_SLT: begin
                op_result    = '0;
                op_result[0] = sum[Msb] ^ ovf_sub;
                op_c         = ~cout;
                op_v         = ovf_sub;
            end
            default: op_result = '0;
        endcase
    end

    always_comb begin
        result_d = result_q;
        sreg_d   = sreg_q;
        if (en) begin
            result_d       = op_result;
            sreg_d[SREG_C] = op_c;
            sreg_d[SREG_Z] = (op_result == '0);
            sreg_d[SREG_N] = op_result[Msb];
            sreg_d[SREG_V] = op_v;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            sreg_q   <= '0;
        end else begin
            result_q <= result_d;
            sreg_q   <= sreg_d;
        end
    end

    assign result = result_q;
    assign sreg   = sreg_q;

endmodule

// File: tb/tb_alu_16bit.sv
// Scoreboard bench for alu_16bit: driver queues expectations, monitor checks them.
module tb_alu_16bit;
    import alu_pkg::*;

    typedef struct {
        string       name;
        logic [15:0] res;
        logic [3:0]  sr;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  alu_op;
    logic [15:0] result;
    logic [3:0]  sreg;

    exp_t exp_q[$];
    int   cyc;
    int   n_tests;
    int   n_fail;

    alu_16bit #(
        .WIDTH(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a     (a),
        .b     (b),
        .ALUOp (alu_op),
        .result(result),
        .sreg  (sreg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Monitor: compare the head entry once its capture edge has passed
    always @(negedge clk or negedge rst_n) begin
        #1;
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests = n_tests + 1;
            if (result !== e.res || sreg !== e.sr) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got result=%h sreg=%b, expected result=%h sreg=%b",
                         e.name, result, sreg, e.res, e.sr);
            end
        end
    end

    task automatic push_exp(input string name, input logic [15:0] r, input logic [3:0] s,
                            input int due);
        exp_t e;
        e.name = name;
        e.res  = r;
        e.sr   = s;
        e.due  = due;
        exp_q.push_back(e);
    endtask

    task automatic issue(input string name, input logic [2:0] op, input logic [15:0] va,
                         input logic [15:0] vb, input logic ven, input logic [15:0] r,
                         input logic [3:0] s);
        @(negedge clk);
        alu_op = op;
        a      = va;
        b      = vb;
        en     = ven;
        push_exp(name, r, s, cyc + 1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        en      = 1'b0;
        a       = '0;
        b       = '0;
        alu_op  = ALU_AND;
        push_exp("reset_init", 16'h0000, 4'b0000, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        issue("and_7_1",      ALU_AND, 16'd7,     16'd1,     1'b1, 16'd1,     4'b0000);
        issue("or_5_2",       ALU_OR,  16'd5,     16'd2,     1'b1, 16'd7,     4'b0000);
        issue("hold_en0",     ALU_ADD, 16'd16,    16'd1,     1'b0, 16'd7,     4'b0000);
        issue("add_16_1",     ALU_ADD, 16'd16,    16'd1,     1'b1, 16'd17,    4'b0000);
        issue("add_ffff_0",   ALU_ADD, 16'hFFFF,  16'd0,     1'b1, 16'hFFFF,  4'b0100);
        issue("add_ffff_1",   ALU_ADD, 16'hFFFF,  16'd1,     1'b1, 16'h0000,  4'b0011);
        issue("add_ffff_2",   ALU_ADD, 16'hFFFF,  16'd2,     1'b1, 16'h0001,  4'b0001);
        issue("sub_15_8",     ALU_SUB, 16'd15,    16'd8,     1'b1, 16'd7,     4'b0000);
        issue("sub_15_15",    ALU_SUB, 16'd15,    16'd15,    1'b1, 16'd0,     4'b0010);
        issue("sub_15_16",    ALU_SUB, 16'd15,    16'd16,    1'b1, 16'hFFFF,  4'b0101);
        issue("add_ovf",      ALU_ADD, 16'h7FFF,  16'd1,     1'b1, 16'h8000,  4'b1100);
        issue("sub_ovf",      ALU_SUB, 16'h8000,  16'd1,     1'b1, 16'h7FFF,  4'b1000);
        issue("slt_m1_1",     ALU_SLT, 16'hFFFF,  16'd1,     1'b1, 16'd1,     4'b0000);
        issue("slt_1_m1",     ALU_SLT, 16'd1,     16'hFFFF,  1'b1, 16'd0,     4'b0011);
        issue("xor",          ALU_XOR, 16'h00FF,  16'h0F0F,  1'b1, 16'h0FF0,  4'b0000);
        issue("nor",          ALU_NOR, 16'h00FF,  16'h0F0F,  1'b1, 16'hF000,  4'b0100);
        issue("mov",          ALU_MOV, 16'h00FF,  16'h0F0F,  1'b1, 16'h0F0F,  4'b0000);

        // Mid-run reset with an op pending: clear must be immediate and the op dropped
        @(negedge clk);
        alu_op = ALU_ADD;
        a      = 16'hFFFF;
        b      = 16'd2;
        en     = 1'b1;
        #2;
        push_exp("reset_async", 16'h0000, 4'b0000, cyc);
        rst_n = 1'b0;
        @(negedge clk);
        push_exp("reset_held", 16'h0000, 4'b0000, cyc);
        #3 rst_n = 1'b1;

        issue("and_after_rst", ALU_AND, 16'd7,    16'd1,     1'b1, 16'd1,     4'b0000);
        issue("hold_after",    ALU_SUB, 16'd1,    16'd2,     1'b0, 16'd1,     4'b0000);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #3;
        if (exp_q.size() > 0) begin
            n_tests = n_tests + 1;
            n_fail  = n_fail + 1;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

endmodule
